// File: rtl/async_fifo_lib.sv
// async_fifo_lib: single-clock first-word-fall-through FIFO, WI bits x 2^L2D entries.
// Define ASYNC_FIFO_LIB_PTR_SYNC_EN to see the opposite pointer through a 2-flop delay on each side.
module async_fifo_lib #(
  parameter int WI  = 16,
  parameter int L2D = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [WI-1:0] w_data,
  input  logic          w_strobe,
  output logic          w_full,
  output logic [L2D:0]  w_level,
  output logic [WI-1:0] r_data,
  input  logic          r_strobe,
  output logic          r_empty,
  output logic [L2D:0]  r_level
);

  localparam logic [L2D:0] DEPTH_C = {1'b1, {L2D{1'b0}}};
  localparam logic [L2D:0] ONE_C   = {{L2D{1'b0}}, 1'b1};
  localparam logic [L2D:0] ZERO_C  = {(L2D+1){1'b0}};

  logic [WI-1:0] mem_r [2**L2D];
  logic [L2D:0]  wptr_r;
  logic [L2D:0]  rptr_r;
  logic [L2D:0]  rptr_view_s;
  logic [L2D:0]  wptr_view_s;
  logic          wr_en_s;
  logic          rd_en_s;

  assign wr_en_s = w_strobe & ~w_full;
  assign rd_en_s = r_strobe & ~r_empty;

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r[L2D-1:0]] <= w_data;
    end
  end

  // Write and read pointers; the MSB is the wrap flag separating full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r <= ZERO_C;
      rptr_r <= ZERO_C;
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + ONE_C;
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + ONE_C;
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

`ifdef ASYNC_FIFO_LIB_PTR_SYNC_EN
  logic [L2D:0] rptr_d1_r;
  logic [L2D:0] rptr_d2_r;
  logic [L2D:0] wptr_d1_r;
  logic [L2D:0] wptr_d2_r;

  // Two-stage delay of each pointer into the opposite side, mimicking a synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_d1_r <= ZERO_C;
      rptr_d2_r <= ZERO_C;
      wptr_d1_r <= ZERO_C;
      wptr_d2_r <= ZERO_C;
    end else begin
      rptr_d1_r <= rptr_r;
      rptr_d2_r <= rptr_d1_r;
      wptr_d1_r <= wptr_r;
      wptr_d2_r <= wptr_d1_r;
    end
  end

  assign rptr_view_s = rptr_d2_r;
  assign wptr_view_s = wptr_d2_r;
`else
  assign rptr_view_s = rptr_r;
  assign wptr_view_s = wptr_r;
`endif

  // Status seen by each side; modulo subtraction keeps the count correct across wraps.
  always_comb begin
    w_level = wptr_r - rptr_view_s;
    r_level = wptr_view_s - rptr_r;
    w_full  = (w_level == DEPTH_C);
    r_empty = (r_level == ZERO_C);
    r_data  = mem_r[rptr_r[L2D-1:0]];
  end

endmodule

// File: tb/tb_async_fifo_lib.sv
// Directed bench for async_fifo_lib in its default build (no pointer-sync delay).
module tb_async_fifo_lib;

  logic        clk;
  logic        reset_n;
  logic [15:0] w_data;
  logic        w_strobe;
  logic        w_full;
  logic [4:0]  w_level;
  logic [15:0] r_data;
  logic        r_strobe;
  logic        r_empty;
  logic [4:0]  r_level;

  int total;
  int bad;

  async_fifo_lib #(.WI(16), .L2D(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .w_data   (w_data),
    .w_strobe (w_strobe),
    .w_full   (w_full),
    .w_level  (w_level),
    .r_data   (r_data),
    .r_strobe (r_strobe),
    .r_empty  (r_empty),
    .r_level  (r_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wcnt;
    logic [15:0] rcnt;
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    w_data   = 16'h0000;
    w_strobe = 1'b0;
    r_strobe = 1'b0;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) tick();
    chk("rst_empty",   {31'd0, r_empty}, 32'd1);
    chk("rst_full",    {31'd0, w_full},  32'd0);
    chk("rst_wlevel",  {27'd0, w_level}, 32'd0);
    chk("rst_rlevel",  {27'd0, r_level}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Fill with 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      w_strobe = 1'b1;
      w_data   = 16'(i);
      tick();
      chk("fill_wlevel", {27'd0, w_level}, 32'(i));
    end
    chk("fill_full",  {31'd0, w_full},  32'd1);
    chk("fill_rlvl",  {27'd0, r_level}, 32'd16);
    chk("fill_head",  {16'd0, r_data},  32'h0001);

    // Overflow write is dropped
    w_data = 16'h0011;
    tick();
    w_strobe = 1'b0;
    chk("ovf_wlevel", {27'd0, w_level}, 32'd16);
    chk("ovf_full",   {31'd0, w_full},  32'd1);
    chk("ovf_head",   {16'd0, r_data},  32'h0001);

    // Drain, sampling r_data in the strobe cycle
    for (int i = 1; i <= 16; i++) begin
      r_strobe = 1'b1;
      chk("drain_data", {16'd0, r_data}, 32'(i));
      tick();
    end
    chk("drain_empty", {31'd0, r_empty}, 32'd1);
    chk("drain_rlvl",  {27'd0, r_level}, 32'd0);

    // Underflow read is ignored
    tick();
    r_strobe = 1'b0;
    chk("udf_rlvl",  {27'd0, r_level}, 32'd0);
    chk("udf_empty", {31'd0, r_empty}, 32'd1);

    // Read+write while empty: only the write lands
    w_strobe = 1'b1;
    r_strobe = 1'b1;
    w_data   = 16'h0100;
    tick();
    r_strobe = 1'b0;
    chk("emp_both_lvl",  {27'd0, w_level}, 32'd1);
    chk("emp_both_head", {16'd0, r_data},  32'h0100);
    w_data = 16'h0101;
    tick();
    w_data = 16'h0102;
    tick();
    chk("lvl3", {27'd0, r_level}, 32'd3);

    // Simultaneous read+write at level 3 for 10 cycles
    r_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_data = 16'h0103 + 16'(i);
      chk("sim_data", {16'd0, r_data}, 32'h0100 + 32'(i));
      tick();
      chk("sim_lvl", {27'd0, w_level}, 32'd3);
    end
    w_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sim_tail", {16'd0, r_data}, 32'h010A + 32'(i));
      tick();
    end
    r_strobe = 1'b0;
    chk("sim_empty", {31'd0, r_empty}, 32'd1);

    // Streaming 40 words forces the pointers to wrap repeatedly
    for (int i = 0; i < 40; i++) begin
      w_strobe = 1'b1;
      w_data   = 16'h0200 + 16'(i);
      r_strobe = (i >= 2);
      if (i >= 2) chk("wrap_data", {16'd0, r_data}, 32'h0200 + 32'(i - 2));
      tick();
    end
    w_strobe = 1'b0;
    r_strobe = 1'b1;
    for (int i = 38; i < 40; i++) begin
      chk("wrap_data", {16'd0, r_data}, 32'h0200 + 32'(i));
      tick();
    end
    r_strobe = 1'b0;
    chk("wrap_empty", {31'd0, r_empty}, 32'd1);

    // Read+write while full: only the read lands
    w_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_data = 16'h0300 + 16'(i);
      tick();
    end
    chk("f2_full", {31'd0, w_full}, 32'd1);
    w_data   = 16'hBEEF;
    r_strobe = 1'b1;
    chk("fb_head", {16'd0, r_data}, 32'h0300);
    tick();
    w_strobe = 1'b0;
    chk("fb_lvl",  {27'd0, w_level}, 32'd15);
    chk("fb_full", {31'd0, w_full},  32'd0);
    for (int i = 1; i < 16; i++) begin
      chk("fb_data", {16'd0, r_data}, 32'h0300 + 32'(i));
      tick();
    end
    r_strobe = 1'b0;
    chk("fb_empty", {31'd0, r_empty}, 32'd1);

    // Random traffic, gated on the visible flags
    wcnt = 16'd1;
    rcnt = 16'd1;
    for (int i = 0; i < 3000; i++) begin
      w_strobe = ($urandom_range(0, 99) < 55) && !w_full;
      r_strobe = ($urandom_range(0, 99) < 50) && !r_empty;
      w_data   = wcnt;
      if (r_strobe) chk("rnd_data", {16'd0, r_data}, {16'd0, rcnt});
      tick();
      if (w_strobe) wcnt = wcnt + 16'd1;
      if (r_strobe) rcnt = rcnt + 16'd1;
    end
    w_strobe = 1'b0;
    r_strobe = 1'b0;
    chk("rnd_level", {27'd0, w_level}, 32'(wcnt - rcnt));

    // Asynchronous reset with 5 entries stored
    r_strobe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!r_empty) tick();
    end
    r_strobe = 1'b0;
    w_strobe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 16'h0400 + 16'(i);
      tick();
    end
    w_strobe = 1'b0;
    chk("mid_lvl5", {27'd0, w_level}, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_wlvl",  {27'd0, w_level}, 32'd0);
    chk("mid_rlvl",  {27'd0, r_level}, 32'd0);
    chk("mid_empty", {31'd0, r_empty}, 32'd1);
    chk("mid_full",  {31'd0, w_full},  32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
